jpeg_enc_quant_zz: RTL



---
 rtl/jpeg_enc_pkg.sv | 30 +++
 rtl/jpeg_enc_quant_round.sv | 45 ++++
 rtl/jpeg_enc_quant_zz.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/jpeg_enc_pkg.sv
// ----------------------------------------------------------------------------
// jpeg_enc_pkg
// Shared constants and types for the JPEG encoder quantisation/zigzag stage.
//   DU_SIZE  : coefficients per data unit (8x8 block)
//   DCT_W    : signed DCT coefficient width
//   FDTBL_W  : unsigned fdtbl scale width
//   ZZ_W     : signed quantised output width
//   IDX_W    : natural / zigzag index width
//   PROD_W   : signed coefficient x scale product width
//   state_e  : quantiser sequencing FSM states
// ----------------------------------------------------------------------------
package jpeg_enc_pkg;

  localparam int DU_SIZE = 64;
  localparam int DCT_W   = 18;
  localparam int FDTBL_W = 8;
  localparam int ZZ_W    = 15;
  localparam int IDX_W   = 6;
  localparam int PROD_W  = DCT_W + FDTBL_W;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DU_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/jpeg_enc_quant_round.sv
// ----------------------------------------------------------------------------
// jpeg_enc_quant_round
// Combinational round-half-up, arithmetic right shift by QSHIFT, then either
// saturate to the ZZ_W signed range or wrap to the low ZZ_W bits.
//   prod  in  PROD_W  signed coefficient x fdtbl product
//   q     out ZZ_W    quantised value (two's complement)
// Build option: define JE_QUANT_SAT_EN to clamp to [-16384, 16383];
// without it the result wraps.
// ----------------------------------------------------------------------------
module jpeg_enc_quant_round
  import jpeg_enc_pkg::*;
#(
  parameter int QSHIFT = 10
) (
  input  logic signed [PROD_W-1:0] prod,
  output logic        [ZZ_W-1:0]   q
);

  // One extra bit so adding the rounding constant can never overflow.
  localparam int SUM_W = PROD_W + 1;
  localparam logic signed [SUM_W-1:0] RND = SUM_W'(1) << (QSHIFT - 1);

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shr;

  assign sum = $signed({prod[PROD_W-1], prod}) + RND;
  assign shr = sum >>> QSHIFT;

`ifdef JE_QUANT_SAT_EN
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (ZZ_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (ZZ_W - 1)));

  always_comb begin
    q = shr[ZZ_W-1:0];
    if (shr > SAT_MAX)      q = SAT_MAX[ZZ_W-1:0];
    else if (shr < SAT_MIN) q = SAT_MIN[ZZ_W-1:0];
  end
`else
  // Wrap mode deliberately drops the high bits of the rounded value.
  logic unused_hi;
  assign unused_hi = ^shr[SUM_W-1:ZZ_W];
  assign q         = shr[ZZ_W-1:0];
`endif

endmodule

// File: rtl/jpeg_enc_quant_zz.sv
// ----------------------------------------------------------------------------
// jpeg_enc_quant_zz
// Quantisation + zigzag reorder of one 64-coefficient block. Walks natural
// index 0..63 across DCTDU RAM, fdtbl ROM and zigzag index ROM in lockstep,
// multiplies coefficient by scale, rounds/shifts (jpeg_enc_quant_round) and
// writes the result into ZIGZAG DU RAM at the ROM-supplied position.
//   clk, reset       clock, synchronous active-high reset
//   start, comp_uv   block request (IDLE only); table select latched at start
//   busy, done       busy for the block, one-cycle done after last write
//   dctdu_ram_ar/do  coefficient read address / data (1-cycle latency)
//   fdtbl_rom_a/d    {comp_uv, idx} / unsigned scale (1-cycle latency)
//   zzidx_rom_a/d    natural index / zigzag destination (1-cycle latency)
//   zzdu_ram_aw/di/we  quantised write port
// Build option: JE_QUANT_SAT_EN selects saturation instead of wrap.
// Timing: start sampled in cycle 0, addresses k in cycle k+1, write for k in
// cycle k+3, done in cycle 67.
// ----------------------------------------------------------------------------
module jpeg_enc_quant_zz
  import jpeg_enc_pkg::*;
#(
  parameter int QSHIFT = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              comp_uv,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  dctdu_ram_ar,
  input  logic [DCT_W-1:0]  dctdu_ram_do,
  output logic [IDX_W:0]    fdtbl_rom_a,
  input  logic [FDTBL_W-1:0] fdtbl_rom_d,
  output logic [IDX_W-1:0]  zzidx_rom_a,
  input  logic [IDX_W-1:0]  zzidx_rom_d,
  output logic [IDX_W-1:0]  zzdu_ram_aw,
  output logic [ZZ_W-1:0]   zzdu_ram_di,
  output logic              zzdu_ram_we
);

  state_e                    state_q,   state_d;
  logic [IDX_W-1:0]          idx_q,     idx_d;
  logic                      comp_uv_q, comp_uv_d;
  logic                      drain_q,   drain_d;
  logic [2:1]                vld_pipe_q, vld_pipe_d;
  logic signed [PROD_W-1:0]  prod_q,    prod_d;
  logic [IDX_W-1:0]          zz_q,      zz_d;

  // vld_pipe[0]: addresses issued; [1]: memory data present; [2]: write.
  logic [2:0]                vld_pipe;
  logic signed [PROD_W-1:0]  prod_c;
  logic [ZZ_W-1:0]           q_c;

  assign vld_pipe[0]   = (state_q == RUN);
  assign vld_pipe[2:1] = vld_pipe_q;

  // Both operands widened to the product width so the multiply is done
  // fully signed at 26 bits (the scale is zero-extended as unsigned).
  assign prod_c = $signed({{FDTBL_W{dctdu_ram_do[DCT_W-1]}}, dctdu_ram_do}) *
                  $signed({{DCT_W{1'b0}}, fdtbl_rom_d});

  // --------------------------------------------------------------------------
  // Sequencing FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    comp_uv_d = comp_uv_q;
    drain_d   = drain_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          idx_d     = '0;
          comp_uv_d = comp_uv;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
          idx_d   = '0;
          drain_d = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        // Two cycles so the last index clears stage B and stage C.
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath pipeline
  // --------------------------------------------------------------------------
  always_comb begin
    vld_pipe_d = vld_pipe[1:0];
    prod_d     = prod_q;
    zz_d       = zz_q;
    if (vld_pipe[1]) begin
      prod_d = prod_c;
      zz_d   = zzidx_rom_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      comp_uv_q  <= 1'b0;
      drain_q    <= 1'b0;
      vld_pipe_q <= '0;
      prod_q     <= '0;
      zz_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      comp_uv_q  <= comp_uv_d;
      drain_q    <= drain_d;
      vld_pipe_q <= vld_pipe_d;
      prod_q     <= prod_d;
      zz_q       <= zz_d;
    end
  end

  jpeg_enc_quant_round #(
    .QSHIFT (QSHIFT)
  ) u_round (
    .prod (prod_q),
    .q    (q_c)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign dctdu_ram_ar = idx_q;
  assign fdtbl_rom_a  = {comp_uv_q, idx_q};
  assign zzidx_rom_a  = idx_q;
  // Write port is forced to zero when idle so stale stage registers never
  // show up on the RAM interface.
  assign zzdu_ram_we  = vld_pipe[2];
  assign zzdu_ram_aw  = vld_pipe[2] ? zz_q : '0;
  assign zzdu_ram_di  = vld_pipe[2] ? q_c  : '0;

endmodule
